// File: rtl/fb_triple_buf_sched_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fb_triple_buf_sched_pkg : slot count, index type, reset indices    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package fb_triple_buf_sched_pkg;

  localparam int FB_NUM_SLOTS = 3;
  localparam int FB_IDX_W     = 2;

  typedef logic [FB_IDX_W-1:0] slot_idx_t;

  localparam slot_idx_t WR_IDX_RST = 2'd0;
  localparam slot_idx_t RD_IDX_RST = 2'd1;
  localparam slot_idx_t SP_IDX_RST = 2'd2;

endpackage
`default_nettype wire

// File: rtl/fb_triple_buf_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fb_triple_buf_sched : triple-buffer writer/reader slot scheduler   |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module fb_triple_buf_sched
  import fb_triple_buf_sched_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE = ADDR_W'(32'h7E9000),
  parameter int unsigned       CNT_W        = 16
) (
  input  logic              pixel_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              wr_frame_done,
  input  logic              rd_vsync,
  output logic [1:0]        wr_idx,
  output logic [1:0]        rd_idx,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              rdy_valid,
  output logic              wr_swap,
  output logic              rd_swap,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  repeat_cnt
);

  localparam logic [ADDR_W-1:0] SLOT0_BASE = BASE_ADDR;
  localparam logic [ADDR_W-1:0] SLOT1_BASE = BASE_ADDR + FRAME_STRIDE;
  localparam logic [ADDR_W-1:0] SLOT2_BASE = BASE_ADDR + FRAME_STRIDE + FRAME_STRIDE;
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  function automatic logic [ADDR_W-1:0] slot_base(input slot_idx_t idx);
    case (idx)
      2'd0:    return SLOT0_BASE;
      2'd1:    return SLOT1_BASE;
      default: return SLOT2_BASE;
    endcase
  endfunction

  slot_idx_t         wr_idx_q, wr_idx_d;
  slot_idx_t         rd_idx_q, rd_idx_d;
  slot_idx_t         sp_idx_q, sp_idx_d;
  logic              rdy_q, rdy_d;
  logic              vs_q;
  logic              wr_swap_q, wr_swap_d;
  logic              rd_swap_q, rd_swap_d;
  logic [ADDR_W-1:0] wr_base_q, rd_base_q;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  rep_q, rep_d;
  logic              wr_ev, rd_ev;

  assign wr_ev = enable & wr_frame_done;
  assign rd_ev = enable & rd_vsync & ~vs_q;

  // Write swap is resolved first so a same-cycle read picks up the frame just finished.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    sp_idx_d  = sp_idx_q;
    rdy_d     = rdy_q;
    wr_swap_d = 1'b0;
    rd_swap_d = 1'b0;
    drop_d    = drop_q;
    rep_d     = rep_q;

    if (wr_ev) begin
      wr_idx_d  = sp_idx_q;
      sp_idx_d  = wr_idx_q;
      rdy_d     = 1'b1;
      wr_swap_d = 1'b1;
      if (rdy_q && (drop_q != CNT_MAX)) drop_d = drop_q + 1'b1;
    end

    if (rd_ev) begin
      if (rdy_d) begin
        rd_idx_d  = sp_idx_d;
        sp_idx_d  = rd_idx_q;
        rdy_d     = 1'b0;
        rd_swap_d = 1'b1;
      end else if (rep_q != CNT_MAX) begin
        rep_d = rep_q + 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      wr_idx_q  <= WR_IDX_RST;
      rd_idx_q  <= RD_IDX_RST;
      sp_idx_q  <= SP_IDX_RST;
      rdy_q     <= 1'b0;
      vs_q      <= 1'b1;
      wr_swap_q <= 1'b0;
      rd_swap_q <= 1'b0;
      wr_base_q <= SLOT0_BASE;
      rd_base_q <= SLOT1_BASE;
      drop_q    <= '0;
      rep_q     <= '0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      sp_idx_q  <= sp_idx_d;
      rdy_q     <= rdy_d;
      vs_q      <= rd_vsync;
      wr_swap_q <= wr_swap_d;
      rd_swap_q <= rd_swap_d;
      wr_base_q <= slot_base(wr_idx_d);
      rd_base_q <= slot_base(rd_idx_d);
      drop_q    <= drop_d;
      rep_q     <= rep_d;
    end
  end

  assign wr_idx     = wr_idx_q;
  assign rd_idx     = rd_idx_q;
  assign wr_base    = wr_base_q;
  assign rd_base    = rd_base_q;
  assign rdy_valid  = rdy_q;
  assign wr_swap    = wr_swap_q;
  assign rd_swap    = rd_swap_q;
  assign drop_cnt   = drop_q;
  assign repeat_cnt = rep_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_triple_buf_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fb_triple_buf_sched : vector table, corner sequences, random    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module tb_fb_triple_buf_sched;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0;
  localparam logic [31:0] STRIDE = 32'h7E9000;
  localparam int          CNT_W  = 4;
  localparam int          MAXC   = 15;

  logic              pixel_clock = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              wr_frame_done = 1'b0;
  logic              rd_vsync = 1'b0;
  logic [1:0]        wr_idx, rd_idx;
  logic [ADDR_W-1:0] wr_base, rd_base;
  logic              rdy_valid, wr_swap, rd_swap;
  logic [CNT_W-1:0]  drop_cnt, repeat_cnt;

  fb_triple_buf_sched #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FRAME_STRIDE(STRIDE), .CNT_W(CNT_W)
  ) dut (
    .pixel_clock(pixel_clock), .reset(reset), .enable(enable),
    .wr_frame_done(wr_frame_done), .rd_vsync(rd_vsync),
    .wr_idx(wr_idx), .rd_idx(rd_idx), .wr_base(wr_base), .rd_base(rd_base),
    .rdy_valid(rdy_valid), .wr_swap(wr_swap), .rd_swap(rd_swap),
    .drop_cnt(drop_cnt), .repeat_cnt(repeat_cnt)
  );

  always #5 pixel_clock = ~pixel_clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: role array {writer, reader, spare} over slot numbers,
  // a "fresh frame waiting" flag and plain saturating tallies.
  int role[3];
  bit m_fresh, m_prev_vs, m_wsw, m_rsw;
  int m_drop, m_rep;

  task automatic model_reset();
    role = '{0, 1, 2};
    m_fresh = 0; m_prev_vs = 1; m_wsw = 0; m_rsw = 0;
    m_drop = 0; m_rep = 0;
  endtask

  task automatic model_step(input bit en, input bit d, input bit vs);
    bit edge_seen;
    int t;
    edge_seen = vs && !m_prev_vs;
    m_prev_vs = vs;
    m_wsw = 0; m_rsw = 0;
    if (en && d) begin
      if (m_fresh) m_drop = (m_drop < MAXC) ? m_drop + 1 : m_drop;
      t = role[0]; role[0] = role[2]; role[2] = t;
      m_fresh = 1; m_wsw = 1;
    end
    if (en && edge_seen) begin
      if (m_fresh) begin
        t = role[1]; role[1] = role[2]; role[2] = t;
        m_fresh = 0; m_rsw = 1;
      end else begin
        m_rep = (m_rep < MAXC) ? m_rep + 1 : m_rep;
      end
    end
  endtask

  function automatic logic [31:0] exp_base(input int idx);
    return BASE + 32'(idx) * STRIDE;
  endfunction

  task automatic check_all();
    logic [1:0] s;
    bit ok;
    s = dut.sp_idx_q;
    chk("wr_idx", wr_idx, role[0]);
    chk("rd_idx", rd_idx, role[1]);
    chk("sp_idx", s, role[2]);
    chk("wr_base", wr_base, exp_base(role[0]));
    chk("rd_base", rd_base, exp_base(role[1]));
    chk("rdy_valid", rdy_valid, m_fresh);
    chk("wr_swap", wr_swap, m_wsw);
    chk("rd_swap", rd_swap, m_rsw);
    chk("drop_cnt", drop_cnt, m_drop);
    chk("repeat_cnt", repeat_cnt, m_rep);
    ok = (wr_idx != 2'd3) && (rd_idx != 2'd3) && (s != 2'd3) &&
         (wr_idx != rd_idx) && (wr_idx != s) && (rd_idx != s);
    chk("permutation", ok, 1'b1);
  endtask

  task automatic step(input bit en, input bit d, input bit vs);
    enable = en; wr_frame_done = d; rd_vsync = vs;
    model_step(en, d, vs);
    @(posedge pixel_clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    enable = 0; wr_frame_done = 0; rd_vsync = 0;
    reset = 0;
    repeat (3) @(posedge pixel_clock);
    #1;
    reset = 1;
    model_reset();
    check_all();
  endtask

  typedef struct {
    bit en, d, vs;
    int wr, rd;
    bit rv, ws, rs;
    int drop, rep;
  } vec_t;

  vec_t tbl[14];
  int   rep_before;
  int   vs_hold;
  bit   vs_lvl;

  initial begin
    tbl[0]  = '{1, 0, 0,  0, 1,  0, 0, 0,  0, 0};
    tbl[1]  = '{1, 1, 0,  2, 1,  1, 1, 0,  0, 0};
    tbl[2]  = '{1, 0, 0,  2, 1,  1, 0, 0,  0, 0};
    tbl[3]  = '{1, 0, 1,  2, 0,  0, 0, 1,  0, 0};
    tbl[4]  = '{1, 0, 1,  2, 0,  0, 0, 0,  0, 0};
    tbl[5]  = '{1, 0, 0,  2, 0,  0, 0, 0,  0, 0};
    tbl[6]  = '{1, 1, 0,  1, 0,  1, 1, 0,  0, 0};
    tbl[7]  = '{1, 1, 0,  2, 0,  1, 1, 0,  1, 0};
    tbl[8]  = '{0, 1, 1,  2, 0,  1, 0, 0,  1, 0};
    tbl[9]  = '{1, 0, 1,  2, 0,  1, 0, 0,  1, 0};
    tbl[10] = '{1, 0, 0,  2, 0,  1, 0, 0,  1, 0};
    tbl[11] = '{1, 1, 1,  1, 2,  0, 1, 1,  2, 0};
    tbl[12] = '{1, 0, 0,  1, 2,  0, 0, 0,  2, 0};
    tbl[13] = '{1, 0, 1,  1, 2,  0, 0, 0,  2, 1};

    // Idle after reset
    do_reset();
    repeat (100) step(1, 0, 0);
    chk("idle_wr_idx", wr_idx, 0);
    chk("idle_rd_idx", rd_idx, 1);

    // Vector table from reset
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].en, tbl[i].d, tbl[i].vs);
      chk("tbl_wr_idx", wr_idx, tbl[i].wr);
      chk("tbl_rd_idx", rd_idx, tbl[i].rd);
      chk("tbl_wr_base", wr_base, exp_base(tbl[i].wr));
      chk("tbl_rd_base", rd_base, exp_base(tbl[i].rd));
      chk("tbl_rdy", rdy_valid, tbl[i].rv);
      chk("tbl_wr_swap", wr_swap, tbl[i].ws);
      chk("tbl_rd_swap", rd_swap, tbl[i].rs);
      chk("tbl_drop", drop_cnt, tbl[i].drop);
      chk("tbl_rep", repeat_cnt, tbl[i].rep);
    end

    // Done then vsync edge 10 cycles later
    do_reset();
    step(1, 1, 0);
    chk("t2_wr_base", wr_base, 32'hFD2000);
    repeat (9) step(1, 0, 0);
    step(1, 0, 1);
    chk("t2_rd_base", rd_base, 32'h0);
    chk("t2_rdy", rdy_valid, 0);

    // Three dones, no vsync
    do_reset();
    step(1, 1, 0); chk("t3_wr_a", wr_idx, 2);
    step(1, 1, 0); chk("t3_wr_b", wr_idx, 0);
    step(1, 1, 0); chk("t3_wr_c", wr_idx, 2);
    chk("t3_drop", drop_cnt, 2);
    chk("t3_rd", rd_idx, 1);

    // Two vsync edges, no done
    do_reset();
    step(1, 0, 0); step(1, 0, 1); step(1, 0, 0); step(1, 0, 1);
    chk("t4_rep", repeat_cnt, 2);
    chk("t4_rd", rd_idx, 1);

    // Simultaneous done and edge from reset
    do_reset();
    step(1, 0, 0);
    step(1, 1, 1);
    chk("t5_sp", dut.sp_idx_q, 1);
    chk("t5_both_swaps", {wr_swap, rd_swap}, 2'b11);
    step(1, 0, 1);
    chk("t5_swaps_clear", {wr_swap, rd_swap}, 2'b00);

    // Enable low ignores events; long vsync high is one event
    do_reset();
    step(0, 1, 0); step(0, 0, 1); step(0, 1, 0); step(0, 0, 0);
    chk("t6_frozen_wr", wr_idx, 0);
    rep_before = m_rep;
    for (int i = 0; i < 50; i++) step(1, 0, 1);
    step(1, 0, 0);
    chk("t6_one_event", repeat_cnt, rep_before + 1);

    // Asynchronous reset mid-cycle, released with vsync high
    step(1, 1, 0); step(1, 1, 0);
    #2;
    reset = 0;
    #1;
    model_reset();
    check_all();
    @(posedge pixel_clock); #1;
    rd_vsync = 1;
    reset = 1;
    step(1, 0, 1);
    chk("t6_no_edge_at_release", repeat_cnt, 0);

    // Counter saturation
    do_reset();
    repeat (20) step(1, 1, 0);
    chk("sat_drop", drop_cnt, MAXC);
    repeat (20) begin step(1, 0, 1); step(1, 0, 0); end
    chk("sat_rep", repeat_cnt, MAXC);

    // Randomised traffic against the model
    do_reset();
    vs_hold = 0; vs_lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (vs_hold == 0) begin
        vs_lvl  = ~vs_lvl;
        vs_hold = $urandom_range(1, 8);
      end
      vs_hold--;
      step($urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0, vs_lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
